// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter: one buffer entry per requester, a single write port.
// Define REGWR_RR_EN for round-robin arbitration between unequal addresses (default: B over A).
module reg_write_arbiter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BUSYWAIT,
    input  logic       A_REQ,
    input  logic [2:0] A_ADDR,
    input  logic [7:0] A_DATA,
    input  logic       B_REQ,
    input  logic [2:0] B_ADDR,
    input  logic [7:0] B_DATA,
    output logic       A_ACK,
    output logic       B_ACK,
    output logic       WRITE,
    output logic [2:0] INADDRESS,
    output logic [7:0] IN
);

    typedef enum logic {IDLE, WR} state_t;

    state_t     state, state_next;
    logic       a_valid, b_valid;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_older;
    logic       a_hold, b_hold;
    logic [2:0] out_addr;
    logic [7:0] out_data;
    logic       a_cap, b_cap;
    logic       load, sel_a;
    logic       a_free, b_free;
    logic       a_stays, b_stays;
    logic       a_older_next;
`ifdef REGWR_RR_EN
    logic       rr_b;
`endif

    // A level held after ACK is the same request; a new one needs REQ to drop first.
    assign a_cap = A_REQ && !a_valid && !A_ACK && !a_hold;
    assign b_cap = B_REQ && !b_valid && !B_ACK && !b_hold;

    always_comb begin
        sel_a = a_valid;
        if (a_valid && b_valid) begin
            if (a_addr == b_addr) begin
                sel_a = a_older;
            end else begin
`ifdef REGWR_RR_EN
                sel_a = !rr_b;
`else
                sel_a = 1'b0;
`endif
            end
        end
    end

    assign load    = (a_valid || b_valid) && ((state == IDLE) || !BUSYWAIT);
    assign a_free  = load && sel_a;
    assign b_free  = load && !sel_a;
    assign a_stays = a_valid && !a_free;
    assign b_stays = b_valid && !b_free;

    // The surviving entry is older than any newcomer; simultaneous captures favour A.
    always_comb begin
        if (a_stays && b_stays) begin
            a_older_next = a_older;
        end else if (b_stays) begin
            a_older_next = 1'b0;
        end else begin
            a_older_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    state_next = WR;
                end
            end
            WR: begin
                if (BUSYWAIT) begin
                    state_next = WR;
                end else if (a_valid || b_valid) begin
                    state_next = WR;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        WRITE     = (state == WR);
        INADDRESS = out_addr;
        IN        = out_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_valid  <= 1'b0;
            b_valid  <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            a_data   <= '0;
            b_data   <= '0;
            a_older  <= 1'b0;
            a_hold   <= 1'b0;
            b_hold   <= 1'b0;
            A_ACK    <= 1'b0;
            B_ACK    <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
`ifdef REGWR_RR_EN
            rr_b     <= 1'b0;
`endif
        end else begin
            A_ACK   <= a_cap;
            B_ACK   <= b_cap;
            a_hold  <= A_REQ && (a_hold || a_cap);
            b_hold  <= B_REQ && (b_hold || b_cap);
            a_valid <= a_cap || a_stays;
            b_valid <= b_cap || b_stays;
            a_older <= a_older_next;
            if (a_cap) begin
                a_addr <= A_ADDR;
                a_data <= A_DATA;
            end
            if (b_cap) begin
                b_addr <= B_ADDR;
                b_data <= B_DATA;
            end
            if (load) begin
                out_addr <= sel_a ? a_addr : b_addr;
                out_data <= sel_a ? a_data : b_data;
`ifdef REGWR_RR_EN
                rr_b     <= sel_a;
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: pending-request model checked every cycle plus directed scenarios.
// Build with REGWR_RR_EN defined to check the round-robin variant.
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       rst, busy, a_req, b_req;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ack, b_ack, write;
    logic [2:0] inaddr;
    logic [7:0] in_data;

    reg_write_arbiter dut (
        .CLK(clk), .RESET(rst), .BUSYWAIT(busy),
        .A_REQ(a_req), .A_ADDR(a_addr), .A_DATA(a_data),
        .B_REQ(b_req), .B_ADDR(b_addr), .B_DATA(b_data),
        .A_ACK(a_ack), .B_ACK(b_ack), .WRITE(write),
        .INADDRESS(inaddr), .IN(in_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         src_b;
        logic [2:0] addr;
        logic [7:0] data;
        int         seq;
    } ent_t;

    // Reference model: set of pending requests with capture order
    ent_t       pend[$];
    int         seq_ctr = 0;
    bit         ptr_b = 0;
    bit         a_blk = 0, b_blk = 0;
    bit         pw = 0;
    logic [2:0] pa = '0;
    logic [7:0] pd = '0;
    bit         s_rst = 1, s_busy = 0, s_areq = 0, s_breq = 0;
    logic [2:0] s_aaddr = '0, s_baddr = '0;
    logic [7:0] s_adata = '0, s_bdata = '0;
    bit         ea, eb, ew, a_in, b_in;
    int         k;

    // Register file as seen through the DUT's write port
    logic [7:0] rf[8];
    int         commits = 0;
    int         commits_at[8];
    int         wr_cycles = 0;
    logic [7:0] load_log[$];
    bit         rand_done = 0;

    function automatic int pick();
        if (pend.size() == 1) return 0;
        if (pend[0].addr == pend[1].addr) return (pend[0].seq < pend[1].seq) ? 0 : 1;
`ifdef REGWR_RR_EN
        return (pend[0].src_b == ptr_b) ? 0 : 1;
`else
        return pend[0].src_b ? 0 : 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (s_rst) begin
            pend.delete();
            ptr_b = 0; a_blk = 0; b_blk = 0; pw = 0;
            check("reset_write", write, 0);
            check("reset_inaddr", inaddr, 0);
            check("reset_in", in_data, 0);
            check("reset_a_ack", a_ack, 0);
            check("reset_b_ack", b_ack, 0);
        end else begin
            a_in = 0; b_in = 0;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i].src_b) b_in = 1; else a_in = 1;
            end
            ea = s_areq && !a_in && !a_blk;
            eb = s_breq && !b_in && !b_blk;
            if (pw && s_busy) begin
                ew = 1;
            end else if (pend.size() > 0) begin
                k = pick();
                ew = 1;
                pa = pend[k].addr;
                pd = pend[k].data;
                ptr_b = !pend[k].src_b;
                pend.delete(k);
                load_log.push_back(in_data);
            end else begin
                ew = 0;
            end
            pw = ew;
            check("write", write, ew);
            if (ew) begin
                check("inaddr", inaddr, pa);
                check("in", in_data, pd);
            end
            check("a_ack", a_ack, ea);
            check("b_ack", b_ack, eb);
            if (ea) pend.push_back('{1'b0, s_aaddr, s_adata, seq_ctr++});
            if (eb) pend.push_back('{1'b1, s_baddr, s_bdata, seq_ctr++});
            a_blk = s_areq && (a_blk || ea);
            b_blk = s_breq && (b_blk || eb);
        end
        wr_cycles += int'(write);
        if (write && !busy && !rst) begin
            rf[inaddr] = in_data;
            commits++;
            commits_at[inaddr]++;
        end
        s_rst = rst; s_busy = busy; s_areq = a_req; s_breq = b_req;
        s_aaddr = a_addr; s_adata = a_data; s_baddr = b_addr; s_bdata = b_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_a(input logic [2:0] ad, input logic [7:0] da, input int extra);
        bit got = 0;
        a_addr = ad; a_data = da; a_req = 1;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got = a_ack;
        end
        if (!got) begin
            fails++; tests++;
            $display("FAIL a_ack_timeout: got no ACK, expected one within 60 cycles");
        end
        repeat (extra) step();
        a_req = 0;
    endtask

    task automatic do_b(input logic [2:0] ad, input logic [7:0] da, input int extra);
        bit got = 0;
        b_addr = ad; b_data = da; b_req = 1;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got = b_ack;
        end
        if (!got) begin
            fails++; tests++;
            $display("FAIL b_ack_timeout: got no ACK, expected one within 60 cycles");
        end
        repeat (extra) step();
        b_req = 0;
    endtask

    task automatic both(input logic [2:0] aa, input logic [7:0] ad,
                        input logic [2:0] ba, input logic [7:0] bd);
        bit ga = 0, gb = 0;
        a_addr = aa; a_data = ad; b_addr = ba; b_data = bd;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 60 && !(ga && gb); i++) begin
            step();
            if (a_ack) begin ga = 1; a_req = 0; end
            if (b_ack) begin gb = 1; b_req = 0; end
        end
        if (!(ga && gb)) begin
            fails++; tests++;
            $display("FAIL both_ack_timeout: got a=%0d b=%0d, expected both ACKs", ga, gb);
        end
        a_req = 0; b_req = 0;
    endtask

    task automatic drive_a(input int n);
        repeat (n) begin
            repeat ($urandom_range(1, 3)) step();
            do_a(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic drive_b(input int n);
        repeat (n) begin
            repeat ($urandom_range(1, 3)) step();
            do_b(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3));
        end
    endtask

    int w0, c0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf[i] = '0;
            commits_at[i] = 0;
        end
        rst = 1; busy = 0; a_req = 0; b_req = 0;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        repeat (3) step();
        rst = 0;

        // Single A write
        w0 = wr_cycles;
        do_a(3'd3, 8'h5A, 0);
        repeat (4) step();
        check("single_r3", rf[3], 'h5A);
        check("single_wr_cycles", wr_cycles - w0, 1);

        // B write stalled 4 cycles
        busy = 1;
        w0 = wr_cycles;
        c0 = commits_at[1];
        do_b(3'd1, 8'hC3, 0);
        repeat (5) step();
        busy = 0;
        repeat (4) step();
        check("stall_wr_cycles", wr_cycles - w0, 5);
        check("stall_commits", commits_at[1] - c0, 1);
        check("stall_r1", rf[1], 'hC3);

        // Same edge, same address: A first
        load_log.delete();
        both(3'd2, 8'h11, 3'd2, 8'h22);
        repeat (5) step();
        check("same_addr_first", (load_log.size() > 0) ? int'(load_log[0]) : -1, 'h11);
        check("same_addr_r2", rf[2], 'h22);

        // Contention on different addresses, fresh from reset
        rst = 1;
        repeat (2) step();
        rst = 0;
        load_log.delete();
        both(3'd4, 8'h44, 3'd5, 8'h55);
        repeat (5) step();
`ifdef REGWR_RR_EN
        check("contention_first", (load_log.size() > 0) ? int'(load_log[0]) : -1, 'h44);
`else
        check("contention_first", (load_log.size() > 0) ? int'(load_log[0]) : -1, 'h55);
`endif
        check("contention_r4", rf[4], 'h44);
        check("contention_r5", rf[5], 'h55);

        // Reset mid-stall with both buffers valid
        busy = 1;
        do_a(3'd6, 8'h66, 0);
        do_b(3'd7, 8'h77, 0);
        do_a(3'd0, 8'h10, 0);
        c0 = commits;
        rst = 1;
        step();
        rst = 0;
        busy = 0;
        repeat (3) step();
        check("rst_stall_commits", commits - c0, 0);
        check("rst_stall_r6", rf[6], 0);
        check("rst_stall_r7", rf[7], 0);
        do_a(3'd6, 8'hA6, 0);
        repeat (4) step();
        check("after_rst_r6", rf[6], 'hA6);

        // REQ held three cycles past ACK
        c0 = commits_at[2];
        do_a(3'd2, 8'h99, 3);
        repeat (6) step();
        check("held_req_commits", commits_at[2] - c0, 1);
        check("held_req_r2", rf[2], 'h99);

        // Randomised traffic with random stalls
        fork
            begin
                fork
                    drive_a(40);
                    drive_b(40);
                join
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    step();
                    busy = ($urandom_range(0, 3) == 0);
                end
            end
        join
        busy = 0;
        repeat (10) step();
        check("drain_write", write, 0);
        check("drain_pending", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
